// File: rtl/dnn_mem_resp_fix8.sv
// Signed fixed-point weight memory: streaming loader FSM plus an always-on 1-cycle read port.
// Define DNN_MEM_CSUM_EN to add the csum output (running sum of accepted load words).
//
// state | meaning
// IDLE  | waiting for load_start
// LOAD  | accepting ld_data words into memory
// DONE  | single-cycle load_done pulse, then back to IDLE
module dnn_mem_resp_fix8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  load_done,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
`ifdef DNN_MEM_CSUM_EN
  output logic [DATA_WIDTH-1:0] csum,
`endif
  output logic                  err_oob
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] cnt_inc;
  logic                  zdone_q, zdone_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_oob, wr_oob, wr_fire, wr_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointer is one bit wider than an address so it never wraps back into range.
  assign rd_oob  = {1'b0, mem_addr} >= DEPTH_P;
  assign wr_oob  = ptr_q >= DEPTH_P;
  assign wr_fire = (state_q == S_LOAD) && ld_valid && !reset;
  assign wr_en   = wr_fire && !wr_oob;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    zdone_d   = 1'b0;
    err_d     = err_q | rd_oob;
    ld_ready  = 1'b0;
    load_done = zdone_q;
    busy      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          if (load_len != '0) begin
            state_d = S_LOAD;
            ptr_d   = {1'b0, load_base};
            cnt_d   = '0;
            len_d   = load_len;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (ld_valid) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_inc;
          if (wr_oob) err_d = 1'b1;
          if (cnt_inc == len_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        load_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Soft clear wins over everything; memory contents are left alone.
    if (reset) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      cnt_d   = '0;
      zdone_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      zdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      zdone_q <= zdone_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; non-blocking update gives read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q[IDXW-1:0]] <= ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rd_oob ? '0 : mem[mem_addr[IDXW-1:0]];
  end

  assign mem_data = rdata_q;
  assign err_oob  = err_q;

`ifdef DNN_MEM_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (reset)                                 csum_d = '0;
    else if (state_q == S_IDLE && load_start)  csum_d = '0;
    else if (wr_fire)                          csum_d = csum_q + ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

endmodule

// File: doc/dnn_mem_resp_fix8.md
DNN_MEM_RESP_FIX8 -- requirements
Module: dnn_mem_resp_fix8

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, memory word width (signed fixed-point); ADDR_WIDTH, 16, address width; DEPTH, 8192, number of words.
REQ-002 clk  input  1  sole clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 reset  input  1  synchronous soft clear: aborts a load and clears status; memory contents are kept.
REQ-005 load_start  input  1  one-cycle pulse; begins a load of load_len words starting at load_base.
REQ-006 load_base  input  ADDR_WIDTH  first write address, sampled on load_start.
REQ-007 load_len  input  ADDR_WIDTH  number of words to load, sampled on load_start.
REQ-008 ld_valid  input  1  load-stream data valid.
REQ-009 ld_data  input  DATA_WIDTH  load-stream word (signed).
REQ-010 ld_ready  output  1  block accepts ld_data this cycle.
REQ-011 load_done  output  1  one-cycle pulse when a load completes.
REQ-012 busy  output  1  high while a load is in progress (state LOAD or DONE).
REQ-013 mem_addr  input  ADDR_WIDTH  inference-engine read address.
REQ-014 mem_data  output  DATA_WIDTH  registered read data (signed).
REQ-015 err_oob  output  1  sticky flag: an out-of-range read or write has occurred.

Function
REQ-016 Reads SHALL be served every cycle with fixed 1-cycle latency: mem_data at edge t+1 = mem[mem_addr sampled at edge t].
REQ-017 A read with mem_addr >= DEPTH SHALL return 0 and set err_oob.
REQ-018 A read and a write to the same address in the same cycle SHALL return the old contents (read-before-write).
REQ-019 Reads SHALL remain available in every FSM state.
REQ-020 The FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-021 IDLE -> LOAD on load_start with load_len != 0; write pointer <= load_base; count <= 0.
REQ-022 load_start with load_len == 0 in IDLE SHALL pulse load_done on the next cycle and remain in IDLE.
REQ-023 In LOAD, ld_ready = 1; each cycle with ld_valid && ld_ready writes ld_data to mem[pointer], increments the pointer and increments the count.
REQ-024 The accepted write that makes count == load_len SHALL cause LOAD -> DONE.
REQ-025 In DONE, ld_ready = 0 and load_done = 1 for exactly one cycle, then DONE -> IDLE.
REQ-026 A write with pointer >= DEPTH SHALL be dropped, set err_oob, and still be counted.
REQ-027 The pointer SHALL NOT wrap modulo DEPTH.
REQ-028 load_start in LOAD or DONE SHALL be ignored.
REQ-029 ld_valid outside LOAD SHALL be ignored.
REQ-030 reset SHALL force the FSM to IDLE and clear ld_ready, load_done, err_oob, the count and the checksum; it has priority over load_start and writes in the same cycle.

Reset
REQ-031 On rst: state IDLE; ld_ready, load_done, busy, err_oob = 0; mem_data = 0; pointer and count = 0; checksum = 0.
REQ-032 Memory array contents SHALL NOT be initialised by rst or reset.
REQ-033 Reset assertion mid-load SHALL abandon the load; words already written are retained.

Configuration
REQ-034 When DNN_MEM_CSUM_EN is defined, the block SHALL add output port csum (DATA_WIDTH bits).
REQ-035 With DNN_MEM_CSUM_EN defined, csum SHALL equal the modulo-2^DATA_WIDTH sum of all accepted load words since the last load_start, including dropped out-of-range words.
REQ-036 With DNN_MEM_CSUM_EN defined, csum SHALL be cleared on load_start, reset and rst, and updated in the same cycle as each accepted word.
REQ-037 When DNN_MEM_CSUM_EN is undefined, port csum and all checksum logic SHALL be absent.

Verification
REQ-038 Load load_base=0x0191, load_len=3, data 0x05,0xFB,0x7F with ld_valid continuous -> busy for 4 cycles; load_done pulses 1 cycle after the third word; reads of 0x0191..0x0193 return 0x05,0xFB,0x7F one cycle after the address; csum=0x7F.
REQ-039 Load with ld_valid toggling 1,0,1,0 -> only cycles with ld_valid && ld_ready are written; load_done timing follows the last accepted word.
REQ-040 Read mem_addr=0x2000 (DEPTH=8192) -> mem_data=0x00 next cycle; err_oob=1 and stays 1 until reset.
REQ-041 load_len=0 -> load_done pulses next cycle; busy stays 0; no memory change.
REQ-042 Assert reset after 2 of 5 words -> state IDLE, ld_ready=0 next cycle; no load_done; the 2 written words are readable.
REQ-043 Same-cycle read and write to 0x0000 (old 0x11, new 0x22) -> mem_data=0x11; the following read returns 0x22.
